// File: rtl/pico_pkg.sv
// pico_pkg: shared pico core types.
// Holds the interrupt controller FSM states and its configuration register selects.
package pico_pkg;

  typedef enum logic [1:0] {
    INTC_IDLE,
    INTC_REQ,
    INTC_SERVICE
  } intc_state_t;

  localparam logic [1:0] CFG_SEL_MASK = 2'd0;
  localparam logic [1:0] CFG_SEL_MODE = 2'd1;
  localparam logic [1:0] CFG_SEL_POL  = 2'd2;

endpackage

// File: rtl/pico_intc_if.sv
// pico_intc_if: configuration bus and core-side handshake of the interrupt controller.
// The master modport is the core side; the slave modport is pico_intc.
interface pico_intc_if #(
  parameter int N_IRQ = 4,
  parameter int VEC_W = 8
);
  logic             cfg_we_i;
  logic [1:0]       cfg_sel_i;
  logic [N_IRQ-1:0] cfg_data_i;
  logic             wfi_i;
  logic             irq_ack_i;
  logic             eoi_i;
  logic             irq_req_o;
  logic [VEC_W-1:0] irq_vec_o;
  logic             wake_o;
  logic [N_IRQ-1:0] pending_o;

  modport master (
    output cfg_we_i, cfg_sel_i, cfg_data_i, wfi_i, irq_ack_i, eoi_i,
    input  irq_req_o, irq_vec_o, wake_o, pending_o
  );

  modport slave (
    input  cfg_we_i, cfg_sel_i, cfg_data_i, wfi_i, irq_ack_i, eoi_i,
    output irq_req_o, irq_vec_o, wake_o, pending_o
  );
endinterface

// File: rtl/pico_intc_chan.sv
// pico_intc_chan: one interrupt channel.
// Optional 2-flop synchroniser (PICO_INTC_SYNC_EN), polarity XOR, edge register, pending flop.
// Level mode shows the registered active level; edge mode latches rises until cleared.
module pico_intc_chan (
  input  logic clk_i,
  input  logic n_rst_i,
  input  logic irq,
  input  logic mode,
  input  logic pol,
  input  logic clr,
  output logic pending
);
  logic irq_s, act, act_q, pend_q;

`ifdef PICO_INTC_SYNC_EN
  logic [1:0] sync_q;

  // two-flop synchroniser for asynchronous sources
  always_ff @(posedge clk_i or negedge n_rst_i)
    if (!n_rst_i) sync_q <= '0;
    else          sync_q <= {sync_q[0], irq};

  assign irq_s = sync_q[1];
`else
  assign irq_s = irq;
`endif

  assign act = irq_s ^ pol;

  // edge register and edge pending flop; a rise wins over a same-cycle clear
  always_ff @(posedge clk_i or negedge n_rst_i)
    if (!n_rst_i) begin
      act_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      act_q  <= act;
      pend_q <= (pend_q & ~clr) | (act & ~act_q);
    end

  assign pending = mode ? act_q : pend_q;
endmodule

// File: rtl/pico_intc.sv
// pico_intc: N_IRQ-channel interrupt controller with fixed-priority arbiter,
// req/ack/eoi handshake and WFI wake. Define PICO_INTC_SYNC_EN to synchronise irq_i.
module pico_intc
  import pico_pkg::*;
#(
  parameter int N_IRQ    = 4,
  parameter int VEC_W    = 8,
  parameter int VEC_BASE = 0
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic [N_IRQ-1:0] irq_i,
  pico_intc_if.slave       bus
);
  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef struct packed {
    logic [IDX_W-1:0] win;
    logic [VEC_W-1:0] vec;
  } req_t;

  logic [N_IRQ-1:0] mask_q, mode_q, pol_q, pend, clr, cand;
  intc_state_t      st_q, st_d;
  req_t             lat_q, lat_d, arb;

  // configuration registers; reserved select is dropped
  always_ff @(posedge clk_i or negedge n_rst_i)
    if (!n_rst_i) begin
      mask_q <= '0;
      mode_q <= '0;
      pol_q  <= '0;
    end else if (bus.cfg_we_i) begin
      case (bus.cfg_sel_i)
        CFG_SEL_MASK: mask_q <= bus.cfg_data_i;
        CFG_SEL_MODE: mode_q <= bus.cfg_data_i;
        CFG_SEL_POL:  pol_q  <= bus.cfg_data_i;
        default: ;
      endcase
    end

  for (genvar i = 0; i < N_IRQ; i++) begin : g_chan
    pico_intc_chan u_chan (
      .clk_i   (clk_i),
      .n_rst_i (n_rst_i),
      .irq     (irq_i[i]),
      .mode    (mode_q[i]),
      .pol     (pol_q[i]),
      .clr     (clr[i]),
      .pending (pend[i])
    );
  end

  assign cand = pend & mask_q;

  // fixed priority: lowest unmasked pending index wins
  always_comb begin
    arb.win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (cand[i]) arb.win = IDX_W'(i);
    arb.vec = VEC_W'(VEC_BASE) + VEC_W'(arb.win);
  end

  // handshake FSM; the latched request stays frozen until eoi
  always_comb begin
    st_d  = st_q;
    lat_d = lat_q;
    clr   = '0;
    case (st_q)
      INTC_IDLE:
        if (|cand) begin
          st_d  = INTC_REQ;
          lat_d = arb;
        end
      INTC_REQ:
        if (bus.irq_ack_i) begin
          st_d           = INTC_SERVICE;
          clr[lat_q.win] = ~mode_q[lat_q.win];
        end
      INTC_SERVICE:
        if (bus.eoi_i) st_d = INTC_IDLE;
      default: st_d = INTC_IDLE;
    endcase
  end

  // state and latched request registers
  always_ff @(posedge clk_i or negedge n_rst_i)
    if (!n_rst_i) begin
      st_q  <= INTC_IDLE;
      lat_q <= '0;
    end else begin
      st_q  <= st_d;
      lat_q <= lat_d;
    end

  assign bus.irq_req_o = (st_q == INTC_REQ);
  assign bus.irq_vec_o = (st_q == INTC_IDLE) ? '0 : lat_q.vec;
  assign bus.wake_o    = bus.wfi_i & (|cand);
  assign bus.pending_o = pend;
endmodule

// File: tb/tb_pico_intc.sv
// tb_pico_intc: directed scenarios plus random traffic, checked every cycle
// against a behavioural channel/handshake model.
module tb_pico_intc;
  import pico_pkg::*;

  localparam int N_IRQ    = 4;
  localparam int VEC_W    = 8;
  localparam int VEC_BASE = 254;
`ifdef PICO_INTC_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif

  logic             clk_i = 1'b0;
  logic             n_rst_i = 1'b0;
  logic [N_IRQ-1:0] irq_i = '0;

  pico_intc_if #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) bus ();

  pico_intc #(.N_IRQ(N_IRQ), .VEC_W(VEC_W), .VEC_BASE(VEC_BASE)) dut (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .irq_i   (irq_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [N_IRQ-1:0] m_mask, m_mode, m_pol, m_pend, m_act, h0, h1;
  int m_st;   // 0 idle, 1 requesting, 2 servicing
  int m_win;

  function automatic logic [VEC_W-1:0] vec_of(input int w);
    return VEC_W'((VEC_BASE + w) % (1 << VEC_W));
  endfunction

  function automatic bit [N_IRQ-1:0] m_pending();
    bit [N_IRQ-1:0] p;
    for (int i = 0; i < N_IRQ; i++) p[i] = m_mode[i] ? m_act[i] : m_pend[i];
    return p;
  endfunction

  task automatic m_reset();
    m_mask = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_act = '0;
    h0 = '0; h1 = '0; m_st = 0; m_win = 0;
  endtask

  task automatic m_step();
    bit [N_IRQ-1:0] src, a, rise, clr, req;
    src  = (SYNC != 0) ? h1 : irq_i;
    a    = src ^ m_pol;
    rise = a & ~m_act;
    req  = m_pending() & m_mask;
    clr  = '0;
    case (m_st)
      0: if (req != '0) begin
           m_st = 1;
           for (int i = N_IRQ - 1; i >= 0; i--) if (req[i]) m_win = i;
         end
      1: if (bus.irq_ack_i) begin
           m_st = 2;
           if (!m_mode[m_win]) clr[m_win] = 1'b1;
         end
      default: if (bus.eoi_i) m_st = 0;
    endcase
    m_pend = (m_pend & ~clr) | rise;
    m_act  = a;
    h1 = h0;
    h0 = irq_i;
    if (bus.cfg_we_i)
      case (bus.cfg_sel_i)
        2'd0: m_mask = bus.cfg_data_i;
        2'd1: m_mode = bus.cfg_data_i;
        2'd2: m_pol  = bus.cfg_data_i;
        default: ;
      endcase
  endtask

  task automatic check_outs(input string tag);
    bit [N_IRQ-1:0] pe;
    pe = m_pending();
    chk({tag, ".req"},  32'(bus.irq_req_o), 32'(m_st == 1));
    chk({tag, ".vec"},  32'(bus.irq_vec_o), (m_st != 0) ? 32'(vec_of(m_win)) : 32'd0);
    chk({tag, ".wake"}, 32'(bus.wake_o),    32'(bus.wfi_i & (|(pe & m_mask))));
    chk({tag, ".pend"}, 32'(bus.pending_o), 32'(pe));
  endtask

  // one clock: model steps on the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk_i);
    if (n_rst_i) m_step();
    @(negedge clk_i);
    check_outs("cyc");
  endtask

  task automatic do_reset();
    n_rst_i = 1'b0;
    m_reset();
    irq_i = '0;
    bus.cfg_we_i = 0; bus.cfg_sel_i = '0; bus.cfg_data_i = '0;
    bus.wfi_i = 0; bus.irq_ack_i = 0; bus.eoi_i = 0;
    tick(); tick();
    n_rst_i = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [N_IRQ-1:0] data);
    bus.cfg_we_i = 1; bus.cfg_sel_i = sel; bus.cfg_data_i = data;
    tick();
    bus.cfg_we_i = 0;
  endtask

  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (!bus.irq_req_o && n < 20) begin tick(); n++; end
    chk({tag, ".req_to"}, 32'(bus.irq_req_o), 32'd1);
  endtask

  task automatic pulse(input logic [N_IRQ-1:0] v);
    irq_i = v;
    tick();
    irq_i = '0;
  endtask

  task automatic ack();  bus.irq_ack_i = 1; tick(); bus.irq_ack_i = 0; endtask
  task automatic eoi();  bus.eoi_i = 1;     tick(); bus.eoi_i = 0;     endtask

  initial begin
    int n;
    bus.cfg_we_i = 0; bus.cfg_sel_i = '0; bus.cfg_data_i = '0;
    bus.wfi_i = 0; bus.irq_ack_i = 0; bus.eoi_i = 0;
    m_reset();

    // 1: single edge on channel 0, latency and handshake
    do_reset();
    chk("t1.rst_pend", 32'(bus.pending_o), 32'd0);
    cfg_write(CFG_SEL_MASK, 4'b0001);
    pulse(4'b0001);
    wait_req("t1", n);
    chk("t1.lat", 32'(n + 1), 32'(2 + 2 * SYNC));
    chk("t1.vec", 32'(bus.irq_vec_o), 32'(vec_of(0)));
    ack();
    chk("t1.ack_pend", 32'(bus.pending_o), 32'd0);
    chk("t1.ack_req", 32'(bus.irq_req_o), 32'd0);
    eoi();
    chk("t1.idle_vec", 32'(bus.irq_vec_o), 32'd0);

    // 2: simultaneous edges on 1 and 2, priority then back-to-back
    do_reset();
    cfg_write(CFG_SEL_MASK, 4'b1111);
    pulse(4'b0110);
    wait_req("t2", n);
    chk("t2.vec1", 32'(bus.irq_vec_o), 32'(vec_of(1)));
    ack();
    eoi();
    chk("t2.gap", 32'(bus.irq_req_o), 32'd0);
    tick();
    chk("t2.req2", 32'(bus.irq_req_o), 32'd1);
    chk("t2.vec2", 32'(bus.irq_vec_o), 32'(vec_of(2)));

    // 3: active-low level channel 3
    do_reset();
    cfg_write(CFG_SEL_MASK, 4'b1000);
    cfg_write(CFG_SEL_MODE, 4'b1000);
    cfg_write(CFG_SEL_POL,  4'b1000);
    wait_req("t3", n);
    chk("t3.vec", 32'(bus.irq_vec_o), 32'(vec_of(3)));
    ack();
    chk("t3.lvl_pend", 32'(bus.pending_o[3]), 32'd1);
    eoi();
    tick();
    chk("t3.rereq", 32'(bus.irq_req_o), 32'd1);
    irq_i = 4'b1000;
    ack();
    eoi();
    repeat (4) tick();
    chk("t3.deassert", 32'(bus.pending_o[3]), 32'd0);

    // 4: masked pending with wfi, then unmask
    do_reset();
    bus.wfi_i = 1;
    pulse(4'b0001);
    repeat (3) tick();
    chk("t4.pend", 32'(bus.pending_o), 32'd1);
    chk("t4.req", 32'(bus.irq_req_o), 32'd0);
    chk("t4.wake0", 32'(bus.wake_o), 32'd0);
    cfg_write(CFG_SEL_MASK, 4'b0001);
    chk("t4.wake1", 32'(bus.wake_o), 32'd1);
    tick();
    chk("t4.req1", 32'(bus.irq_req_o), 32'd1);
    bus.wfi_i = 0;

    // 5: new edge on channel 0 lands on the ack edge
    do_reset();
    cfg_write(CFG_SEL_MASK, 4'b0001);
    pulse(4'b0001);
    wait_req("t5", n);
    irq_i = 4'b0001;
    for (int j = 0; j < 2 * SYNC; j++) begin tick(); irq_i = '0; end
    ack();
    irq_i = '0;
    chk("t5.pend", 32'(bus.pending_o[0]), 32'd1);
    eoi();
    tick();
    chk("t5.rereq", 32'(bus.irq_req_o), 32'd1);

    // 6: asynchronous reset during service
    do_reset();
    cfg_write(CFG_SEL_MASK, 4'b0011);
    cfg_write(CFG_SEL_POL,  4'b0010);
    wait_req("t6", n);
    ack();
    n_rst_i = 1'b0;
    #1;
    m_reset();
    chk("t6.req", 32'(bus.irq_req_o), 32'd0);
    chk("t6.vec", 32'(bus.irq_vec_o), 32'd0);
    chk("t6.pend", 32'(bus.pending_o), 32'd0);
    tick();
    n_rst_i = 1'b1;
    bus.wfi_i = 1;
    pulse(4'b0001);
    repeat (3) tick();
    chk("t6.mask_clr", 32'(bus.irq_req_o), 32'd0);
    chk("t6.wake", 32'(bus.wake_o), 32'd0);
    chk("t6.pol_clr", 32'(bus.pending_o), 32'd1);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_IRQ; i++)
        if ($urandom_range(0, 4) == 0) irq_i[i] = ~irq_i[i];
      bus.cfg_we_i   = ($urandom_range(0, 19) == 0);
      bus.cfg_sel_i  = 2'($urandom_range(0, 3));
      bus.cfg_data_i = N_IRQ'($urandom);
      bus.wfi_i      = 1'($urandom);
      bus.irq_ack_i  = ($urandom_range(0, 2) == 0);
      bus.eoi_i      = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pico_intc.md
# pico_intc

Parametrised interrupt controller for the pico core. It replaces the single-input edge detector on the core's external interrupt path with N_IRQ configurable channels. Each channel has its own mask, edge/level mode and polarity. A fixed-priority arbiter drives a request/acknowledge/end-of-interrupt handshake and a vector number toward the decoder, and a wake output releases the core from WFI.

## Interface
Parameters:
- N_IRQ, 4, number of interrupt channels (1..8)
- VEC_W, 8, vector output width (matches pico_N)
- VEC_BASE, 0, value added to the winning channel index to form the vector

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge
- n_rst_i  in  1  reset; asynchronous, active-low
- irq_i  in  N_IRQ  raw interrupt lines; may be asynchronous
- cfg_we_i  in  1  configuration write strobe
- cfg_sel_i  in  2  target register: 0 = mask, 1 = mode, 2 = polarity, 3 = reserved (write ignored)
- cfg_data_i  in  N_IRQ  write data, one bit per channel
- wfi_i  in  1  core is in WFI
- irq_ack_i  in  1  core accepts the current request
- eoi_i  in  1  core has finished servicing the interrupt
- irq_req_o  out  1  interrupt request to the decoder
- irq_vec_o  out  VEC_W  vector of the request being presented or serviced
- wake_o  out  1  wake the core from WFI
- pending_o  out  N_IRQ  pending flags, before masking

## Operation
Configuration registers:
- mask: bit = 1 enables the channel.
- mode: bit = 0 selects edge mode; bit = 1 selects level mode.
- pol: bit = 0 means active-high; bit = 1 means active-low.
- A write loads cfg_data_i into the selected register on the clock edge. The new value takes effect from the next cycle.

Channel condition:
- Active level: act[i] = sync(irq_i[i]) XOR pol[i].
- Edge mode: a 0→1 transition of act sets pending[i]. Acknowledging the channel clears it. If a set and a clear occur in the same cycle, the set wins.
- Level mode: pending[i] = act[i], combinationally from the registered act. It is not latched, and ack has no effect on it.
- Mask gates arbitration and wake only. Pending still latches while a channel is masked.

Arbitration:
- win is the lowest index i with pending[i] & mask[i].
- Vector = VEC_BASE + win, truncated to VEC_W bits.

State machine (intc_state_t):
- IDLE → REQ when any pending & mask bit is set. On that transition, win and the vector are latched.
- REQ → SERVICE on irq_ack_i. If the latched channel is in edge mode, its pending bit is cleared.
- SERVICE → IDLE on eoi_i. There is no nesting; new events only stay pending.
- Ignored inputs: irq_ack_i outside REQ, and eoi_i outside SERVICE.
- In REQ the latched vector is frozen. A later mask, pending or mode change does not withdraw the request.

Outputs:
- irq_req_o = (state == REQ).
- irq_vec_o holds the latched vector in REQ and SERVICE, and is 0 in IDLE.
- wake_o = wfi_i & |(pending & mask). It is combinational and independent of state.

## Timing
Reset values: state IDLE; mask, mode, pol, pending, synchronisers and edge registers all 0; irq_req_o = 0; irq_vec_o = 0; wake_o = 0; pending_o = 0.

Latency, with irq_i sampled high at edge k (previous value low):
- With sync: pending is set at edge k+2 and irq_req_o rises after edge k+3.
- Without sync: pending is set at edge k and irq_req_o rises after edge k+1.

Handshake:
- Ack sampled at edge m: irq_req_o falls after edge m, and the pending bit is clear from edge m.
- EOI sampled at edge n: state returns to IDLE at edge n. If another channel is pending and unmasked, the next request rises after edge n+1.

Boundary cases:
- A new edge on the serviced channel during SERVICE re-pends that channel and is served after EOI.
- All channels masked: the FSM stays in IDLE and wake_o = 0.
- Reset mid-REQ or mid-SERVICE: everything returns to the reset values immediately (asynchronously).

## Configuration
- PICO_INTC_SYNC_EN defined: each irq_i passes through a 2-flop synchroniser before polarity and edge detection.
- Not defined: irq_i feeds polarity and edge logic directly, for synchronous sources. Latency drops by 2 cycles.

## Structure
- Shared package pico_pkg gets:
  - intc_state_t {INTC_IDLE, INTC_REQ, INTC_SERVICE}
  - CFG_SEL_MASK = 0, CFG_SEL_MODE = 1, CFG_SEL_POL = 2
- One sub-module, pico_intc_chan, instantiated N_IRQ times. It contains the optional synchroniser, the polarity XOR, the edge register and the pending flop. Its inputs are mode, pol and clear; its output is pending.
- The arbiter, FSM and config registers live in pico_intc.

## Test plan
1. Reset, mask = 4'b0001, mode = 0, pulse irq_i[0] for 1 cycle → irq_req_o high 4 cycles after the sample (sync on), irq_vec_o = 0; ack → pending_o = 0; eoi → back to IDLE.
2. Mask = 4'b1111, raise irq_i[2] and irq_i[1] in the same cycle → vector 1 served first; after eoi, vector 2 requested on the following cycle.
3. Mode[3] = 1, pol[3] = 1, hold irq_i[3] = 0 → continuous pending_o[3] = 1; after ack and eoi it re-requests; driving irq_i[3] = 1 → pending_o[3] = 0.
4. Mask = 0, pulse irq_i[0] with wfi_i = 1 → pending_o = 4'b0001, irq_req_o = 0, wake_o = 0; then write mask = 1 → wake_o = 1 next cycle, followed by a request.
5. Edge on channel 0 in the same cycle as ack of channel 0 → pending_o[0] stays 1 and is re-requested after eoi.
6. Assert n_rst_i = 0 during SERVICE → irq_req_o = 0, irq_vec_o = 0, all config registers 0, before the next clock edge.
